// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the integer and
// FP issue stages. Operands are registered for the whole EXEC window and the
// result is returned to the winner over a valid/ready response channel.

// Per-requester response holding register: loads on capture, else holds.
module alu_arbiter_resp #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Capture the ALU result and flags; the value persists after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (cap) q <= d;
    end
endmodule

module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int INT_LAT = 1,
    parameter int FP_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req0_float,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic              req1_float,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,
    output logic              resp0_fp_cc,
    output logic              resp0_overflow,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,
    output logic              resp1_fp_cc,
    output logic              resp1_overflow,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_is_float,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_fp_cc,
    input  logic              alu_overflow,
    output logic              busy
);
    localparam int NUM_REQ = 2;
    localparam int LAT_MAX = (INT_LAT > FP_LAT) ? INT_LAT : FP_LAT;
    localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);
    localparam int RESP_W  = DATA_W + 3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              fp_cc;
        logic              overflow;
    } resp_t;

    state_t state_q, state_d;
    logic             owner, last, grant;
    logic [CNT_W-1:0] cnt;

    logic [NUM_REQ-1:0]             req_valid, req_ready, req_float, resp_ready, resp_valid, cap;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a, req_b;
    logic [NUM_REQ-1:0][OP_W-1:0]   req_op;
    resp_t [NUM_REQ-1:0]            resp_q;
    resp_t                          alu_resp;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_float  = {req1_float, req0_float};
    assign req_a      = {req1_a, req0_a};
    assign req_b      = {req1_b, req0_b};
    assign req_op     = {req1_op, req0_op};
    assign resp_ready = {resp1_ready, resp0_ready};
    assign alu_resp   = '{result: alu_result, zero: alu_zero, fp_cc: alu_fp_cc, overflow: alu_overflow};

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        grant = 1'b0;
        if (&req_valid)        grant = ~last;
        else if (req_valid[1]) grant = 1'b1;
    end

    // Ready, response valid and capture strobes decoded per requester.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        cap        = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            req_ready[n]  = (state_q == IDLE) && req_valid[n] && (grant == 1'(n));
            resp_valid[n] = (state_q == RESP) && (owner == 1'(n));
            cap[n]        = (state_q == EXEC) && (cnt == '0) && (owner == 1'(n));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid)        state_d = EXEC;
            EXEC:    if (cnt == '0)         state_d = RESP;
            RESP:    if (resp_ready[owner]) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Operand latch, ownership and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_is_float <= 1'b0;
            owner        <= 1'b0;
            last         <= 1'b1;
            cnt          <= '0;
        end else if (state_q == IDLE && |req_valid) begin
            alu_a        <= req_a[grant];
            alu_b        <= req_b[grant];
            alu_op       <= req_op[grant];
            alu_is_float <= req_float[grant];
            owner        <= grant;
            last         <= grant;
            cnt          <= req_float[grant] ? CNT_W'(FP_LAT - 1) : CNT_W'(INT_LAT - 1);
        end else if (state_q == EXEC && cnt != '0) begin
            cnt          <= cnt - 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_resp
            alu_arbiter_resp #(.W(RESP_W)) u_resp (
                .clk (clk),
                .rst (rst),
                .cap (cap[g]),
                .d   (alu_resp),
                .q   (resp_q[g])
            );
        end
    endgenerate

    assign req0_ready     = req_ready[0];
    assign req1_ready     = req_ready[1];
    assign resp0_valid    = resp_valid[0];
    assign resp1_valid    = resp_valid[1];
    assign resp0_result   = resp_q[0].result;
    assign resp0_zero     = resp_q[0].zero;
    assign resp0_fp_cc    = resp_q[0].fp_cc;
    assign resp0_overflow = resp_q[0].overflow;
    assign resp1_result   = resp_q[1].result;
    assign resp1_zero     = resp_q[1].zero;
    assign resp1_fp_cc    = resp_q[1].fp_cc;
    assign resp1_overflow = resp_q[1].overflow;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed stimulus with a response scoreboard and a
// small ALU stub standing in for the shared datapath.
module tb_alu_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, req0_float = 0, req1_float = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic        resp0_valid, resp1_valid, resp0_ready = 1, resp1_ready = 1;
    logic [31:0] resp0_result, resp1_result;
    logic        resp0_zero, resp0_fp_cc, resp0_overflow;
    logic        resp1_zero, resp1_fp_cc, resp1_overflow;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_is_float, alu_zero, alu_fp_cc, alu_overflow, busy;

    int errors = 0, checks = 0;

    typedef struct {
        logic        port;
        logic [31:0] result;
        logic        zero, fp_cc, ovf;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_float(req0_float),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_float(req1_float),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_zero(resp0_zero), .resp0_fp_cc(resp0_fp_cc), .resp0_overflow(resp0_overflow),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_zero(resp1_zero), .resp1_fp_cc(resp1_fp_cc), .resp1_overflow(resp1_overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_float(alu_is_float),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_fp_cc(alu_fp_cc),
        .alu_overflow(alu_overflow), .busy(busy)
    );

    // ALU stub: 1=add, 2=sub, 6=and, else or; float path returns a^b, fp_cc=(a<b).
    always_comb begin
        alu_result   = alu_a | alu_b;
        alu_fp_cc    = 1'b0;
        alu_overflow = 1'b0;
        if (alu_is_float) begin
            alu_result = alu_a ^ alu_b;
            alu_fp_cc  = (alu_a < alu_b);
        end else begin
            case (alu_op)
                4'd1: begin
                    alu_result   = alu_a + alu_b;
                    alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
                end
                4'd2:    alu_result = alu_a - alu_b;
                4'd6:    alu_result = alu_a & alu_b;
                default: alu_result = alu_a | alu_b;
            endcase
        end
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic p, input logic [31:0] r, input logic z, input logic c, input logic o);
        exp_t e;
        e.port = p; e.result = r; e.zero = z; e.fp_cc = c; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    // Monitor: on every response handshake pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp0_valid && resp1_valid) begin
                errors++; checks++;
                $display("FAIL resp_both_valid: got 1 expected 0");
            end
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                logic        p;
                logic [31:0] r;
                logic        z, c, o;
                p = resp1_valid;
                r = p ? resp1_result : resp0_result;
                z = p ? resp1_zero : resp0_zero;
                c = p ? resp1_fp_cc : resp0_fp_cc;
                o = p ? resp1_overflow : resp0_overflow;
                if (sb.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_resp: port %0d result %h with none expected", p, r);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_port", 32'(p), 32'(e.port));
                    chk("resp_result", r, e.result);
                    chk("resp_flags", {29'd0, z, c, o}, {29'd0, e.zero, e.fp_cc, e.ovf});
                end
            end
        end
    end

    initial begin
        int t;
        int n0, n1;
        logic [31:0] a0 [3], b0 [3], a1 [3], b1 [3];

        // Reset state
        tick(); @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
        chk("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 0);
        tick(); rst = 1'b0;

        // Single int request on port 0: 5+7
        req0_a = 5; req0_b = 7; req0_op = 4'd1; req0_float = 0; req0_valid = 1;
        push(0, 32'd12, 0, 0, 0);
        @(negedge clk);
        chk("t1_ready0_c0", 32'(req0_ready), 1);
        chk("t1_ready1_c0", 32'(req1_ready), 0);
        tick(); req0_valid = 0;
        @(negedge clk);
        chk("t1_alu_a_c1", alu_a, 32'd5);
        chk("t1_busy_c1", 32'(busy), 1);
        chk("t1_resp0_c1", 32'(resp0_valid), 0);
        tick(); @(negedge clk);
        chk("t1_resp0_c2", 32'(resp0_valid), 1);
        tick(); @(negedge clk);
        chk("t1_idle_c3", 32'(busy), 0);
        drain();

        // Tie from reset: port 0 first (3-3 -> zero), then port 1 (F0&3C)
        do_reset();
        req0_a = 3; req0_b = 3; req0_op = 4'd2; req0_valid = 1;
        req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 4'd6; req1_float = 0; req1_valid = 1;
        push(0, 32'd0, 1, 0, 0);
        push(1, 32'h30, 0, 0, 0);
        @(negedge clk);
        chk("t2_tie_ready0", 32'(req0_ready), 1);
        chk("t2_tie_ready1", 32'(req1_ready), 0);
        tick(); req0_valid = 0;
        t = 1;
        @(negedge clk);
        while (!req1_ready && t < 20) begin tick(); t++; @(negedge clk); end
        chk("t2_grant1_cycle", 32'(t), 32'd3);
        tick(); req1_valid = 0;
        drain();

        // Float on port 1: 2 EXEC cycles, a^b with fp_cc=(a<b)
        req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 4'd1; req1_float = 1; req1_valid = 1;
        push(1, 32'hFF, 0, 1, 0);
        @(negedge clk);
        chk("t3_ready1", 32'(req1_ready), 1);
        tick(); req1_valid = 0; req1_float = 0;
        @(negedge clk);
        chk("t3_resp1_c1", 32'(resp1_valid), 0);
        tick(); @(negedge clk);
        chk("t3_resp1_c2", 32'(resp1_valid), 0);
        tick(); @(negedge clk);
        chk("t3_resp1_c3", 32'(resp1_valid), 1);
        drain();

        // Backpressure on resp0 while req1 waits
        resp0_ready = 0;
        req0_a = 1; req0_b = 2; req0_op = 4'd1; req0_valid = 1;
        push(0, 32'd3, 0, 0, 0);
        push(1, 32'd9, 0, 0, 0);
        tick(); req0_valid = 0;
        req1_a = 4; req1_b = 5; req1_op = 4'd1; req1_valid = 1;
        t = 0;
        @(negedge clk);
        while (!resp0_valid && t < 20) begin tick(); t++; @(negedge clk); end
        chk("t4_resp0_seen", 32'(resp0_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_result", resp0_result, 32'd3);
            chk("t4_ready1_low", 32'(req1_ready), 0);
            chk("t4_busy", 32'(busy), 1);
            tick(); @(negedge clk);
        end
        tick(); resp0_ready = 1;
        tick(); @(negedge clk);
        chk("t4_ready1_after", 32'(req1_ready), 1);
        tick(); req1_valid = 0;
        drain();

        // Sustained contention: 6 ops, grants must alternate starting at 0
        a0[0] = 1; b0[0] = 1; a0[1] = 2; b0[1] = 2; a0[2] = 32'h7FFF_FFFF; b0[2] = 1;
        a1[0] = 32'hFF; b1[0] = 32'h0F; a1[1] = 32'hF0; b1[1] = 32'h0F; a1[2] = 32'h3C; b1[2] = 32'h3C;
        push(0, 32'd2, 0, 0, 0);
        push(1, 32'h0F, 0, 0, 0);
        push(0, 32'd4, 0, 0, 0);
        push(1, 32'h00, 1, 0, 0);
        push(0, 32'h8000_0000, 0, 0, 1);
        push(1, 32'h3C, 0, 0, 0);
        n0 = 0; n1 = 0;
        req0_op = 4'd1; req1_op = 4'd6;
        req0_a = a0[0]; req0_b = b0[0]; req0_valid = 1;
        req1_a = a1[0]; req1_b = b1[0]; req1_valid = 1;
        for (int k = 0; k < 6; k++) begin
            t = 0;
            @(negedge clk);
            while (!req0_ready && !req1_ready && t < 20) begin tick(); t++; @(negedge clk); end
            chk("t5_grant", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            tick();
            if (n0 < 3) begin req0_a = a0[n0]; req0_b = b0[n0]; end else req0_valid = 0;
            if (n1 < 3) begin req1_a = a1[n1]; req1_b = b1[n1]; end else req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0;
        drain();

        // Asynchronous reset mid-EXEC discards the in-flight op
        req0_a = 9; req0_b = 9; req0_op = 4'd1; req0_float = 1; req0_valid = 1;
        tick(); req0_valid = 0; req0_float = 0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_alu_a", alu_a, 0);
        chk("t6_rst_alu_ctl", {27'd0, alu_op, alu_is_float}, 0);
        chk("t6_rst_resp1_result", resp1_result, 0);
        chk("t6_rst_resp0_result", resp0_result, 0);
        tick(); tick(); rst = 1'b0;
        repeat (5) tick();
        chk("t6_no_stale", 32'(sb.size()), 0);
        req0_a = 6; req0_b = 2; req0_op = 4'd2; req0_valid = 1;
        req1_a = 6; req1_b = 3; req1_op = 4'd6; req1_valid = 1;
        push(0, 32'd4, 0, 0, 0);
        push(1, 32'd2, 0, 0, 0);
        @(negedge clk);
        chk("t6_tie_ready0", 32'(req0_ready), 1);
        tick(); req0_valid = 0;
        t = 0;
        @(negedge clk);
        while (!req1_ready && t < 20) begin tick(); t++; @(negedge clk); end
        chk("t6_ready1", 32'(req1_ready), 1);
        tick(); req1_valid = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
